// File: rtl/can_init_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : can_init_sequencer_if
//  Description : Bus bundle between the CAN init sequencer, its init-value
//                lookup table and the CAN controller register port.
//                master = sequencer side, slave = table/controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface can_init_sequencer_if;
    logic        start;
    logic [4:0]  init_addr;
    logic [15:0] data_init;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_wr_ack;
    logic        reg_rd;
    logic        reg_rd_ack;
    logic [15:0] reg_rdata;
    logic        busy;
    logic        done;
    logic        init_err;
    logic [2:0]  err_idx;

    modport master (
        input  start, data_init, reg_wr_ack, reg_rd_ack, reg_rdata,
        output init_addr, reg_addr, reg_wdata, reg_wr, reg_rd,
               busy, done, init_err, err_idx
    );

    modport slave (
        output start, data_init, reg_wr_ack, reg_rd_ack, reg_rdata,
        input  init_addr, reg_addr, reg_wdata, reg_wr, reg_rd,
               busy, done, init_err, err_idx
    );
endinterface
`default_nettype wire

// File: rtl/can_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : can_init_sequencer
//  Description : Writes a fixed seven-step init table into a CAN controller
//                (0x0F,0x0E,0x05,0x04,0x11,0x10,0x12) with per-access ack
//                timeout, error capture and one-cycle done pulse.
//                Optional macro INIT_READBACK_EN: read back and verify each
//                register after its write.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_init_sequencer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    can_init_sequencer_if.master bus
);

    localparam logic [7:0] C_TIMEOUT  = 8'(ACK_TIMEOUT);
    localparam logic [2:0] C_LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WRITE = 3'd2,
`ifdef INIT_READBACK_EN
        S_READ  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [7:0]  timer_q;
    logic [4:0]  init_addr_q;
    logic [4:0]  reg_addr_q;
    logic [15:0] reg_wdata_q;
    logic        reg_wr_q;
    logic        busy_q;
    logic        done_q;
    logic        init_err_q;
    logic [2:0]  err_idx_q;

    logic [2:0]  idx_d;
    logic [4:0]  next_addr_d;
    logic [7:0]  timer_d;
    logic        step_last;

    // Register 0x12 (interrupt/enable) is deliberately the final step so the
    // controller is fully configured before it can raise interrupts.
    function automatic logic [4:0] step_addr(input logic [2:0] i);
        case (i)
            3'd0:    step_addr = 5'h0F;
            3'd1:    step_addr = 5'h0E;
            3'd2:    step_addr = 5'h05;
            3'd3:    step_addr = 5'h04;
            3'd4:    step_addr = 5'h11;
            3'd5:    step_addr = 5'h10;
            default: step_addr = 5'h12;
        endcase
    endfunction

    // Next step index, its table address and the incremented ack timer.
    always_comb begin
        idx_d       = idx_q + 3'd1;
        next_addr_d = step_addr(idx_d);
        timer_d     = timer_q + 8'd1;
        step_last   = (idx_q == C_LAST_IDX);
    end

`ifdef INIT_READBACK_EN
    logic reg_rd_q;
`else
    // Readback inputs are not used when verification is compiled out.
    logic w_unused_rb;
    assign w_unused_rb = &{1'b0, bus.reg_rd_ack, bus.reg_rdata};
`endif

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            timer_q     <= 8'd0;
            init_addr_q <= 5'd0;
            reg_addr_q  <= 5'd0;
            reg_wdata_q <= 16'd0;
            reg_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            init_err_q  <= 1'b0;
            err_idx_q   <= 3'd0;
`ifdef INIT_READBACK_EN
            reg_rd_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q     <= S_FETCH;
                        idx_q       <= 3'd0;
                        init_addr_q <= step_addr(3'd0);
                        busy_q      <= 1'b1;
                        init_err_q  <= 1'b0;
                        err_idx_q   <= 3'd0;
                    end
                end
                S_FETCH: begin
                    // data_init is the table's combinational answer to init_addr.
                    reg_addr_q  <= init_addr_q;
                    reg_wdata_q <= bus.data_init;
                    reg_wr_q    <= 1'b1;
                    timer_q     <= 8'd0;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    // Ack is checked before the timeout so a last-cycle ack wins.
                    if (bus.reg_wr_ack) begin
                        reg_wr_q <= 1'b0;
`ifdef INIT_READBACK_EN
                        reg_rd_q <= 1'b1;
                        timer_q  <= 8'd0;
                        state_q  <= S_READ;
`else
                        if (step_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q       <= idx_d;
                            init_addr_q <= next_addr_d;
                            state_q     <= S_FETCH;
                        end
`endif
                    end else if (timer_d == C_TIMEOUT) begin
                        state_q    <= S_ERROR;
                        init_err_q <= 1'b1;
                        err_idx_q  <= idx_q;
                        reg_wr_q   <= 1'b0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`ifdef INIT_READBACK_EN
                S_READ: begin
                    if (bus.reg_rd_ack) begin
                        reg_rd_q <= 1'b0;
                        if (bus.reg_rdata != reg_wdata_q) begin
                            state_q    <= S_ERROR;
                            init_err_q <= 1'b1;
                            err_idx_q  <= idx_q;
                        end else if (step_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q       <= idx_d;
                            init_addr_q <= next_addr_d;
                            state_q     <= S_FETCH;
                        end
                    end else if (timer_d == C_TIMEOUT) begin
                        state_q    <= S_ERROR;
                        init_err_q <= 1'b1;
                        err_idx_q  <= idx_q;
                        reg_rd_q   <= 1'b0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    // init_err/err_idx stay sticky until the next accepted start.
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    init_addr_q <= 5'd0;
                    idx_q       <= 3'd0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.init_addr = init_addr_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.init_err  = init_err_q;
    assign bus.err_idx   = err_idx_q;
`ifdef INIT_READBACK_EN
    assign bus.reg_rd    = reg_rd_q;
`else
    assign bus.reg_rd    = 1'b0;
`endif

endmodule
`default_nettype wire
